// File: rtl/kmeans_result_reader_if.sv
// Output beat stream of the k-means result reader.
// Master drives the beat; slave returns ready.
interface kmeans_result_reader_if #(
  parameter int ADDR_W  = 6,
  parameter int COORD_W = 8,
  parameter int LABEL_W = 3
);
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [COORD_W-1:0] out_z;
  logic [LABEL_W-1:0] out_label;
  logic [ADDR_W-1:0]  out_index;
  logic               out_last;

  modport master (
    output out_valid, out_x, out_y, out_z,
    output out_label, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_z,
    input  out_label, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/kmeans_result_reader.sv
// Walks point memory after clustering, streams (x,y,z,label)
// beats and accumulates a per-cluster population histogram.
module kmeans_result_reader #(
  parameter int N_POINTS = 41,
  parameter int ADDR_W   = 6,
  parameter int COORD_W  = 8,
  parameter int K        = 7,
  parameter int LABEL_W  = 3,
  parameter int CNT_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done_o,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [COORD_W-1:0]   rd_x,
  input  logic [COORD_W-1:0]   rd_y,
  input  logic [COORD_W-1:0]   rd_z,
  input  logic [LABEL_W-1:0]   rd_label,
  kmeans_result_reader_if.master ob,
  output logic [K*CNT_W-1:0]   hist_flat,
  output logic [CNT_W-1:0]     bad_label_cnt
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, SEND, FIN
  } state_t;

  localparam logic [ADDR_W-1:0]  LAST_IDX =
    ADDR_W'(N_POINTS - 1);
  localparam logic [LABEL_W:0]   K_L = (LABEL_W + 1)'(K);

  state_t             state;
  logic [ADDR_W-1:0]  idx;
  logic [CNT_W-1:0]   cnt [K];

  for (genvar g = 0; g < K; g++) begin : g_hist
    assign hist_flat[g*CNT_W +: CNT_W] = cnt[g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done_o        <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      ob.out_valid  <= 1'b0;
      ob.out_x      <= '0;
      ob.out_y      <= '0;
      ob.out_z      <= '0;
      ob.out_label  <= '0;
      ob.out_index  <= '0;
      ob.out_last   <= 1'b0;
      bad_label_cnt <= '0;
      for (int j = 0; j < K; j++) cnt[j] <= '0;
    end else begin
      done_o <= 1'b0;
      rd_en  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= ISSUE;
            busy          <= 1'b1;
            idx           <= '0;
            rd_en         <= 1'b1;
            rd_addr       <= '0;
            bad_label_cnt <= '0;
            for (int j = 0; j < K; j++) cnt[j] <= '0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          ob.out_x     <= rd_x;
          ob.out_y     <= rd_y;
          ob.out_z     <= rd_z;
          ob.out_label <= rd_label;
          ob.out_index <= idx;
          ob.out_last  <= (idx == LAST_IDX);
          ob.out_valid <= 1'b1;
          state        <= SEND;
        end
        SEND: begin
          if (ob.out_ready) begin
            ob.out_valid <= 1'b0;
            // Out-of-range labels go to a separate counter
            if ({1'b0, ob.out_label} < K_L) begin
              for (int j = 0; j < K; j++)
                if (ob.out_label == LABEL_W'(j))
                  cnt[j] <= cnt[j] + 1'b1;
            end else begin
              bad_label_cnt <= bad_label_cnt + 1'b1;
            end
            if (ob.out_last) begin
              state  <= FIN;
              done_o <= 1'b1;
              busy   <= 1'b0;
            end else begin
              idx     <= idx + 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= idx + 1'b1;
              state   <= ISSUE;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_result_reader.sv
// Scoreboard bench for kmeans_result_reader: random data and
// ready patterns checked against a point-list reference model.
module tb_kmeans_result_reader;
  localparam int N  = 41;
  localparam int AW = 6;
  localparam int CW = 8;
  localparam int K  = 7;
  localparam int LW = 3;
  localparam int NW = 6;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] z;
    logic [LW-1:0] l;
    logic [AW-1:0] i;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done_o, rd_en;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_x, rd_y, rd_z;
  logic [LW-1:0] rd_label;
  logic [K*NW-1:0] hist_flat;
  logic [NW-1:0] bad_label_cnt;

  logic [CW-1:0] mx [2**AW];
  logic [CW-1:0] my [2**AW];
  logic [CW-1:0] mz [2**AW];
  logic [LW-1:0] ml [2**AW];

  beat_t exp_q[$];
  beat_t cur, hb, e;
  bit    held;
  int    vectors = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    last_hs = -100;
  int    rmode   = 0;

  always #5 clk = ~clk;

  kmeans_result_reader_if #(
    .ADDR_W(AW), .COORD_W(CW), .LABEL_W(LW)
  ) ob ();

  kmeans_result_reader #(
    .N_POINTS(N), .ADDR_W(AW), .COORD_W(CW),
    .K(K), .LABEL_W(LW), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done_o(done_o),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z),
    .rd_label(rd_label), .ob(ob),
    .hist_flat(hist_flat),
    .bad_label_cnt(bad_label_cnt)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_x     <= mx[rd_addr];
      rd_y     <= my[rd_addr];
      rd_z     <= mz[rd_addr];
      rd_label <= ml[rd_addr];
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ob.out_ready = 1'b1;
      1:       ob.out_ready = 1'($urandom % 2);
      2:       ob.out_ready = 1'b0;
      default: ob.out_ready = (ob.out_index != AW'(20));
    endcase
  end

  assign cur = {ob.out_x, ob.out_y, ob.out_z,
                ob.out_label, ob.out_index, ob.out_last};

  task automatic chk(input string n,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) chk("stable", 64'(cur), 64'(hb));
      if (ob.out_valid && ob.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'(cur), 64'd0 - 1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", e.i), 64'(cur), 64'(e));
        end
        if (ob.out_last) last_hs = cyc;
        held = 1'b0;
      end else begin
        held = ob.out_valid;
        hb   = cur;
      end
      if (done_o) chk("done_timing", 64'(cyc), 64'(last_hs + 1));
    end
  end

  task automatic load_base();
    for (int i = 0; i < N; i++) begin
      mx[i] = CW'($urandom);
      my[i] = CW'($urandom);
      mz[i] = CW'($urandom);
      ml[i] = (i < 35) ? LW'(i / 5) : '0;
    end
    mx[10] = 8'd90;
    my[10] = 8'd20;
    mz[10] = 8'd70;
  endtask

  task automatic push_expected();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b = {mx[i], my[i], mz[i], ml[i], AW'(i), (i == N - 1)};
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start();
    int lat;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    lat = 1;
    while (!ob.out_valid && lat < 10) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("first_latency", 64'(lat), 64'd3);
  endtask

  task automatic run(input int poke);
    int eh [K];
    int eb, t;
    bit poked;
    eb = 0;
    for (int j = 0; j < K; j++) eh[j] = 0;
    for (int i = 0; i < N; i++)
      if (int'(ml[i]) < K) eh[ml[i]]++;
      else eb++;
    push_expected();
    pulse_start();
    t = 0;
    poked = 1'b0;
    while (!done_o && t < 2000) begin
      @(posedge clk); #2;
      t++;
      if (poke >= 0 && !poked && ob.out_valid &&
          ob.out_index == AW'(poke)) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(done_o), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    for (int j = 0; j < K; j++)
      chk($sformatf("hist%0d", j),
          64'(hist_flat[j*NW +: NW]), 64'(eh[j]));
    chk("bad_label_cnt", 64'(bad_label_cnt), 64'(eb));
  endtask

  task automatic reset_mid();
    int t, dn;
    rmode = 3;
    push_expected();
    pulse_start();
    t = 0;
    while (!(ob.out_valid && ob.out_index == AW'(20)) &&
           t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("reach_idx20", 64'(ob.out_index), 64'd20);
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    chk("mid_valid", 64'(ob.out_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rd_en", 64'(rd_en), 64'd0);
    chk("mid_hist", 64'(hist_flat), 64'd0);
    chk("mid_bad", 64'(bad_label_cnt), 64'd0);
    chk("mid_index", 64'(ob.out_index), 64'd0);
    chk("mid_x", 64'(ob.out_x), 64'd0);
    dn = int'(done_o);
    repeat (6) begin
      @(posedge clk); #2;
      dn += int'(done_o) + int'(ob.out_valid);
    end
    chk("mid_quiet", 64'(dn), 64'd0);
    exp_q.delete();
    rmode = 0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    load_base();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(ob.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_hist", 64'(hist_flat), 64'd0);
    chk("rst_bad", 64'(bad_label_cnt), 64'd0);
    rst = 1'b0;

    rmode = 0;
    run(-1);
    load_base();
    rmode = 1;
    run(-1);
    ml[3] = 3'd7;
    rmode = 0;
    run(-1);
    ml[3] = 3'd0;
    rmode = 1;
    run(12);
    rmode = 0;
    run(-1);
    reset_mid();
    load_base();
    rmode = 1;
    run(-1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
